playlist_sequencer: RTL

Parametrised successor to the four-song player. Walks a playlist of NUM_TRACKS note ROMs, generating the read address and track select, and scaling the returned note word into the tone-generator output. Adds over the previous player: async reset, explicit step tick, next/prev skip, repeat-one mode, no-repeat shuffle, per-track length bus, zero-length track skip, saturating scale, and a status/track_done output. Sits between the ROM bank (external mux on rom_track) and the tone/PWM stage.

---
 rtl/playlist_pkg.sv | 25 ++
 rtl/note_scaler.sv | 43 ++++
 rtl/playlist_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/playlist_pkg.sv
// Shared constants and types for the playlist sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: play-mode encodings, FSM state enum, and the prev-button restart
// threshold (address at or beyond which prev restarts the current track).
package playlist_pkg;

  localparam logic [1:0] MODE_SEQ     = 2'd0;
  localparam logic [1:0] MODE_SHUF    = 2'd1;
  localparam logic [1:0] MODE_CHOICE  = 2'd2;
  localparam logic [1:0] MODE_REPEAT  = 2'd3;

  localparam int PREV_RESTART_THRESH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_PAUSED,
    ST_END,
    ST_SELECT
  } state_t;

endpackage

// File: rtl/note_scaler.sv
// Scales a ROM note word by SCALE_NUM / 2^SCALE_SHIFT, saturating to DATA_W bits.
// Latency: 1 clk (registered result).
// Backpressure: none; a new word is accepted every cycle.
//
// Ports:
//   clk, rst_n  - clock, async active-low reset (result clears to 0)
//   din         - raw note word from ROM
//   dout        - min((din * SCALE_NUM) >> SCALE_SHIFT, 2^DATA_W-1)
module note_scaler #(
  parameter int DATA_W      = 16,
  parameter int SCALE_NUM   = 89478,
  parameter int SCALE_SHIFT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  // 18 spare bits hold the full product of a DATA_W word and an 18-bit constant.
  localparam int PROD_W = DATA_W + 18;
  localparam logic [PROD_W-1:0] SCALE_K = PROD_W'(SCALE_NUM);
  localparam logic [PROD_W-1:0] SAT_MAX = PROD_W'({DATA_W{1'b1}});

  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] shifted;

  always_comb begin
    prod    = PROD_W'(din) * SCALE_K;
    shifted = prod >> SCALE_SHIFT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (shifted > SAT_MAX) begin
      dout <= '1;
    end else begin
      dout <= shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/playlist_sequencer.sv
// Walks a playlist of note ROMs (seq/shuffle/choice/repeat), drives ROM address/bank, scales notes out.
// Latency: rom_addr/rom_track registered; out_data follows the ROM word by 1 clk.
// Backpressure: none; position advances only on step, pause holds position.
//
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   step                  - note-rate advance pulse
//   pause                 - level; freezes position and mutes out_data
//   mode                  - 0 seq, 1 shuffle, 2 choice, 3 repeat-one
//   choice                - track for mode 2
//   next, prev            - skip pulses (next wins if both)
//   rand_in               - random track index for shuffle
//   track_len             - per-track lengths, track i at [i*ADDR_W +: ADDR_W]
//   rom_addr, rom_track   - ROM read address / bank select
//   rom_data              - ROM word, valid one clk after address
//   out_data              - scaled, saturated note word (0 unless playing)
//   cur_track, playing    - status
//   track_done            - one-cycle pulse when a track ends naturally
module playlist_sequencer
  import playlist_pkg::*;
#(
  parameter int NUM_TRACKS  = 4,
  parameter int TRK_W       = $clog2(NUM_TRACKS),
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 16,
  parameter int SCALE_NUM   = 89478,
  parameter int SCALE_SHIFT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         step,
  input  logic                         pause,
  input  logic [1:0]                   mode,
  input  logic [TRK_W-1:0]             choice,
  input  logic                         next,
  input  logic                         prev,
  input  logic [TRK_W-1:0]             rand_in,
  input  logic [NUM_TRACKS*ADDR_W-1:0] track_len,
  output logic [ADDR_W-1:0]            rom_addr,
  output logic [TRK_W-1:0]             rom_track,
  input  logic [DATA_W-1:0]            rom_data,
  output logic [DATA_W-1:0]            out_data,
  output logic [TRK_W-1:0]             cur_track,
  output logic                         playing,
  output logic                         track_done
);

  localparam logic [TRK_W-1:0]  LAST_TRK   = TRK_W'(NUM_TRACKS - 1);
  localparam logic [ADDR_W-1:0] RESTART_TH = ADDR_W'(PREV_RESTART_THRESH);

  state_t             state;
  logic [TRK_W-1:0]   cur;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  scaled;

  logic [ADDR_W-1:0]  cur_len;
  logic [TRK_W-1:0]   trk_inc;
  logic [TRK_W-1:0]   trk_dec;
  logic [TRK_W-1:0]   sel_trk;
  logic               rand_ok;
  logic               choice_ok;
  logic               choice_jump;
  logic               last_step;
  logic               prev_restart;

  // ROM bank and status both come from the one track register, so they can never disagree.
  assign rom_addr  = addr;
  assign rom_track = cur;
  assign cur_track = cur;

  // Scaler runs every cycle; muting is applied on its registered result.
  assign out_data = playing ? scaled : '0;

  always_comb begin
    cur_len      = track_len[int'(cur)*ADDR_W +: ADDR_W];
    trk_inc      = (cur == LAST_TRK) ? '0 : cur + 1'b1;
    trk_dec      = (cur == '0) ? LAST_TRK : cur - 1'b1;
    // Shuffle never repeats the current track and rejects out-of-range draws.
    rand_ok      = (32'(rand_in) < 32'(NUM_TRACKS)) && (rand_in != cur);
    choice_ok    = 32'(choice) < 32'(NUM_TRACKS);
    choice_jump  = (mode == MODE_CHOICE) && choice_ok && (choice != cur);
    last_step    = (addr == cur_len - 1'b1);
    prev_restart = (addr >= RESTART_TH);

    sel_trk = cur;
    case (mode)
      MODE_SEQ:    sel_trk = trk_inc;
      MODE_SHUF:   sel_trk = rand_ok ? rand_in : trk_inc;
      MODE_CHOICE: sel_trk = choice_ok ? choice : cur;
      default:     sel_trk = cur;
    endcase
  end

  // playing and track_done are decoded from the transition being taken so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur        <= '0;
      addr       <= '0;
      playing    <= 1'b0;
      track_done <= 1'b0;
    end else begin
      playing    <= 1'b0;
      track_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cur   <= '0;
          addr  <= '0;
          state <= ST_LOAD;
        end

        // Address and bank were set on entry; one cycle lets the ROM answer.
        ST_LOAD: begin
          if (cur_len == '0) begin
            state <= ST_SELECT;
          end else if (pause) begin
            state <= ST_PAUSED;
          end else begin
            state   <= ST_PLAY;
            playing <= 1'b1;
          end
        end

        ST_PLAY, ST_PAUSED: begin
          if (next) begin
            state <= ST_SELECT;
          end else if (prev) begin
            state <= ST_LOAD;
            addr  <= '0;
            if (!prev_restart) begin
              cur <= trk_dec;
            end
          end else if ((state == ST_PLAY) && choice_jump) begin
            state <= ST_LOAD;
            cur   <= choice;
            addr  <= '0;
          end else if (pause) begin
            state <= ST_PAUSED;
          end else if (state == ST_PAUSED) begin
            state   <= ST_PLAY;
            playing <= 1'b1;
          end else if (step && last_step) begin
            state      <= ST_END;
            track_done <= 1'b1;
          end else begin
            playing <= 1'b1;
            if (step) begin
              addr <= addr + 1'b1;
            end
          end
        end

        ST_END: begin
          state <= ST_SELECT;
        end

        ST_SELECT: begin
          cur   <= sel_trk;
          addr  <= '0;
          state <= ST_LOAD;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  note_scaler #(
    .DATA_W      (DATA_W),
    .SCALE_NUM   (SCALE_NUM),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_scaler (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rom_data),
    .dout  (scaled)
  );

endmodule
